// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiplier job scheduler:
//   - default WIDTH / DEPTH / TIMEOUT values used as parameter defaults
//   - FSM state type and state encodings (plain 2-bit constants so that
//     older tools and waveform scripts see stable numeric values)
// No ports (package).
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/mult_job_fifo.sv
// -----------------------------------------------------------------------------
// mult_job_fifo
// Circular job FIFO holding {a, b} operand pairs for the scheduler.
// Push is ignored when full, pop is ignored when empty; a simultaneous push
// and pop both take effect and leave the occupancy unchanged.
// The head entry is presented combinationally on rd_a / rd_b.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset (pointers and count only)
//   push         in   write request
//   wr_a, wr_b   in   operands to store
//   pop          in   remove head entry
//   rd_a, rd_b   out  head entry operands
//   full, empty  out  occupancy flags
//   count        out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module mult_job_fifo
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_a,
  input  logic [WIDTH-1:0]       wr_b,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_a,
  output logic [WIDTH-1:0]       rd_b,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage carries no reset: entries are only read once written.
  logic [2*WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push_ok, pop_ok;

  // Explicit wrap at DEPTH-1 keeps the pointer correct even if the
  // pointer width were ever wider than log2(DEPTH).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_next = push_ok ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = pop_ok  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_next  = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= {wr_a, wr_b};
    end
  end

  assign {rd_a, rd_b} = mem[rd_ptr_reg];
  assign count        = count_reg;

endmodule

// File: rtl/mult_job_scheduler.sv
// -----------------------------------------------------------------------------
// mult_job_scheduler
// Queues multiply jobs and feeds them one at a time to an external
// multiplier core, then presents each product on a valid/ready output.
// FSM: IDLE -> ISSUE (one-cycle start) -> WAIT (for productDone) -> HOLD
// (out_valid until accepted) -> IDLE. Jobs never overlap. The job FIFO keeps
// accepting new jobs in every state.
//
// Optional feature, macro MULT_SCHED_TIMEOUT_EN:
//   defined   - a WAIT-cycle counter drops the job after TIMEOUT cycles without
//               productDone, sets the sticky err flag and returns to IDLE.
//   undefined - no counter, err tied low, WAIT persists until productDone.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      job input handshake, in_a/in_b operands
//   start, mult_a, mult_b  drive the multiplier core
//   productDone, product   result from the multiplier core
//   out_valid/out_ready    result handshake, out_product result
//   busy                   FSM not in IDLE
//   count                  FIFO occupancy (includes the job in flight)
//   err                    sticky timeout flag
// -----------------------------------------------------------------------------
module mult_job_scheduler
  import mult_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   start,
  output logic [WIDTH-1:0]       mult_a,
  output logic [WIDTH-1:0]       mult_b,
  input  logic                   productDone,
  input  logic [2*WIDTH-1:0]     product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_product,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("mult_job_scheduler: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  state_t             state_reg, state_next;
  logic               start_reg;
  logic [WIDTH-1:0]   mult_a_reg, mult_b_reg;
  logic               out_valid_reg;
  logic [2*WIDTH-1:0] out_product_reg;

  logic               fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [WIDTH-1:0]   head_a, head_b;
  logic               timeout_hit;
  logic               issue_now;

  mult_job_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wr_a  (in_a),
    .wr_b  (in_b),
    .pop   (fifo_pop),
    .rd_a  (head_a),
    .rd_b  (head_b),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Leaving IDLE with work queued: operands and start are registered on this
  // edge so they are valid exactly during the ISSUE cycle.
  assign issue_now = (state_reg == ST_IDLE) && !fifo_empty;

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      ST_IDLE:  if (!fifo_empty) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        // The head stays queued while in flight; it is popped only when the
        // job finishes (result or timeout).
        if (productDone) begin
          fifo_pop   = 1'b1;
          state_next = ST_HOLD;
        end else if (timeout_hit) begin
          fifo_pop   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_HOLD:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      start_reg       <= 1'b0;
      mult_a_reg      <= '0;
      mult_b_reg      <= '0;
      out_valid_reg   <= 1'b0;
      out_product_reg <= '0;
    end else begin
      state_reg <= state_next;
      start_reg <= issue_now;
      if (issue_now) begin
        mult_a_reg <= head_a;
        mult_b_reg <= head_b;
      end
      if (state_reg == ST_WAIT && productDone) begin
        out_product_reg <= product;
        out_valid_reg   <= 1'b1;
      end else if (state_reg == ST_HOLD && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;

  logic [TO_W-1:0] wait_cnt_reg;
  logic            err_reg;

  // wait_cnt_reg holds the number of WAIT cycles already spent, so the
  // TIMEOUT-th WAIT cycle is the one that sees TIMEOUT-1.
  assign timeout_hit = (wait_cnt_reg == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == ST_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
      end else begin
        wait_cnt_reg <= '0;
      end
      if (state_reg == ST_WAIT && !productDone && timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign in_ready    = !fifo_full;
  assign start       = start_reg;
  assign mult_a      = mult_a_reg;
  assign mult_b      = mult_b_reg;
  assign out_valid   = out_valid_reg;
  assign out_product = out_product_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mult_job_scheduler.sv
`timescale 1ns/1ps
module tb_mult_job_scheduler;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a = '0;
  logic [WIDTH-1:0]     in_b = '0;
  logic                 start;
  logic [WIDTH-1:0]     mult_a;
  logic [WIDTH-1:0]     mult_b;
  logic                 productDone = 1'b0;
  logic [2*WIDTH-1:0]   product = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [2*WIDTH-1:0]   out_product;
  logic                 busy;
  logic [CW-1:0]        count;
  logic                 err;

  always #5 clk = ~clk;

  mult_job_scheduler #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .start       (start),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .productDone (productDone),
    .product     (product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy),
    .count       (count),
    .err         (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model: job queue + expected result queue -------
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } job_t;

  job_t               job_q[$];
  logic [2*WIDTH-1:0] res_q[$];
  logic [2*WIDTH-1:0] got_q[$];

  bit                 mon_en = 1'b0;
  bit                 prev_start, prev_ov, prev_hs, mon_hs, mon_acc;
  logic [2*WIDTH-1:0] prev_prod;

  // Monitor: samples at the falling edge, predicts what the next rising edge
  // does to the queue, and scores every handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst) begin
        n_checks++;
        if (count !== CW'(job_q.size())) begin
          n_fail++; $display("FAIL count: got %0d expected %0d", count, job_q.size());
        end
        n_checks++;
        if (in_ready !== (job_q.size() < DEPTH)) begin
          n_fail++; $display("FAIL in_ready: got %b expected %b", in_ready, job_q.size() < DEPTH);
        end
        if (start) begin
          n_checks++;
          if (prev_start || out_valid) begin
            n_fail++; $display("FAIL start_pulse: prev_start=%b out_valid=%b expected 0/0", prev_start, out_valid);
          end
          n_checks++;
          if (job_q.size() == 0 || mult_a !== job_q[0].a || mult_b !== job_q[0].b) begin
            n_fail++; $display("FAIL issue_operands: got %h*%h expected head of %0d-entry queue", mult_a, mult_b, job_q.size());
          end
        end
        if (prev_ov && out_valid && !prev_hs) begin
          n_checks++;
          if (out_product !== prev_prod) begin
            n_fail++; $display("FAIL hold_stable: got %h expected %h", out_product, prev_prod);
          end
        end
        mon_hs = out_valid && out_ready;
        if (mon_hs) begin
          n_checks++;
          if (res_q.size() == 0 || out_product !== res_q[0]) begin
            n_fail++; $display("FAIL result: got %h expected %h", out_product, (res_q.size() != 0) ? res_q[0] : 'x);
          end else begin
            $display("txn result product=%h", out_product);
          end
          if (res_q.size() != 0) void'(res_q.pop_front());
          got_q.push_back(out_product);
        end
`ifndef MULT_SCHED_TIMEOUT_EN
        n_checks++;
        if (err !== 1'b0) begin
          n_fail++; $display("FAIL err_tied: got %b expected 0", err);
        end
`endif
        mon_acc = in_valid && (job_q.size() < DEPTH);
        if (productDone && job_q.size() != 0) begin
          res_q.push_back(32'(job_q[0].a) * 32'(job_q[0].b));
          void'(job_q.pop_front());
        end
        if (mon_acc) begin
          job_q.push_back('{a: in_a, b: in_b});
          $display("txn push a=%h b=%h", in_a, in_b);
        end
        prev_start = start;
        prev_ov    = out_valid;
        prev_prod  = out_product;
        prev_hs    = mon_hs;
      end else begin
        prev_start = 1'b0;
        prev_ov    = 1'b0;
        prev_hs    = 1'b0;
        prev_prod  = '0;
      end
    end
  end

  // ---------------- multiplier core model --------------------------------------
  int                 core_lat  = 4;
  bit                 core_rand = 1'b0;
  bit                 core_mute = 1'b0;
  bit                 core_busy = 1'b0;
  int                 core_cnt  = 0;
  logic [2*WIDTH-1:0] core_res  = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      productDone = 1'b0;
      product     = 32'($urandom);  // garbage between results
      if (!rst) begin
        core_busy = 1'b0;
        core_cnt  = 0;
      end else begin
        if (core_busy) begin
          if (core_cnt == 0) begin
            productDone = 1'b1;
            product     = core_res;
            core_busy   = 1'b0;
          end else begin
            core_cnt--;
          end
        end
        if (start && !core_mute) begin
          core_busy = 1'b1;
          core_res  = 32'(mult_a) * 32'(mult_b);
          core_cnt  = (core_rand ? int'($urandom_range(1, 6)) : core_lat) - 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers -------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output bit ok);
    in_valid = 1'b1; in_a = a; in_b = b; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && count == '0 && !out_valid && job_q.size() == 0 && res_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (start !== 1'b0)     begin n_fail++; $display("FAIL reset_start: got %b expected 0", start); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_product !== '0) begin n_fail++; $display("FAIL reset_out_product: got %h expected 0", out_product); end
    n_checks++; if (mult_a !== '0 || mult_b !== '0) begin n_fail++; $display("FAIL reset_mult_ab: got %h/%h expected 0/0", mult_a, mult_b); end
    n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (count !== '0)       begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_empty_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    bit ok, found;
    int done_k, ov_k;
    core_rand = 1'b0; core_lat = 4; out_ready = 1'b1; got_q.delete();
    push_job(16'd3, 16'd5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_push: accepted %b expected 1", ok); end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL single_start: start seen %b expected 1", found); end
    done_k = -1; ov_k = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (productDone && done_k < 0) done_k = i;
      if (out_valid) begin
        ov_k = i;
        n_checks++; if (out_product !== 32'd15) begin n_fail++; $display("FAIL single_product: got %0d expected 15", out_product); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hold: got %b expected 1", busy); end
        break;
      end
    end
    n_checks++; if (done_k != 4) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected 4", done_k); end
    n_checks++; if (ov_k != 5) begin n_fail++; $display("FAIL single_out_valid_cycle: got %0d expected 5", ov_k); end
    wait_idle(200, ok);
    n_checks++; if (!ok || got_q.size() != 1) begin n_fail++; $display("FAIL single_drain: idle %b results %0d expected 1/1", ok, got_q.size()); end
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0]   va [4];
    logic [WIDTH-1:0]   vb [4];
    logic [2*WIDTH-1:0] vr [4];
    bit ok;
    va = '{16'd2, 16'd4, 16'd7, 16'hFFFF};
    vb = '{16'd3, 16'd5, 16'd7, 16'hFFFF};
    vr = '{32'd6, 32'd20, 32'd49, 32'hFFFE0001};
    core_rand = 1'b0; core_lat = 20; out_ready = 1'b1; got_q.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
      tick();
    end
    in_a = 16'd9; in_b = 16'd9;  // fifth job, must be refused
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (count !== CW'(4) || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: count %0d in_ready %b expected 4/0", count, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    wait_idle(400, ok);
    n_checks++; if (!ok || got_q.size() != 4) begin n_fail++; $display("FAIL fill_drain: idle %b results %0d expected 1/4", ok, got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== vr[i]) begin n_fail++; $display("FAIL fill_order[%0d]: got %h expected %h", i, got_q[i], vr[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok, found;
    core_rand = 1'b0; core_lat = 3; out_ready = 1'b0; got_q.delete();
    push_job(16'd11, 16'd13, ok);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL bp_out_valid: seen %b expected 1", found); end
    for (int c = 0; c < 10; c++) begin
      tick();
      in_valid = (c < 2); in_a = 16'(c + 2); in_b = 16'(c + 2);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_product !== 32'd143 || start !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold: out_valid %b product %0d start %b expected 1/143/0", out_valid, out_product, start);
      end
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (count !== CW'(2)) begin n_fail++; $display("FAIL bp_push_in_hold: count %0d expected 2", count); end
    tick();
    out_ready = 1'b1;
    wait_idle(300, ok);
    n_checks++; if (!ok || got_q.size() != 3) begin n_fail++; $display("FAIL bp_drain: idle %b results %0d expected 1/3", ok, got_q.size()); end
    if (got_q.size() == 3) begin
      n_checks++; if (got_q[1] !== 32'd4 || got_q[2] !== 32'd9) begin n_fail++; $display("FAIL bp_queued: got %0d,%0d expected 4,9", got_q[1], got_q[2]); end
    end
  endtask

  task automatic test_push_pop();
    bit ok, found;
    core_rand = 1'b0; core_lat = 8; out_ready = 1'b1; got_q.delete();
    push_job(16'd4, 16'd4, ok);
    push_job(16'd5, 16'd6, ok);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (productDone) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL pp_done: seen %b expected 1", found); end
    in_valid = 1'b1; in_a = 16'd7; in_b = 16'd8;
    @(negedge clk);
    n_checks++; if (count !== CW'(2)) begin n_fail++; $display("FAIL pp_count_before: got %0d expected 2", count); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (count !== CW'(2)) begin n_fail++; $display("FAIL pp_count_after: got %0d expected 2", count); end
    wait_idle(300, ok);
    n_checks++; if (!ok || got_q.size() != 3) begin n_fail++; $display("FAIL pp_drain: idle %b results %0d expected 1/3", ok, got_q.size()); end
    if (got_q.size() == 3) begin
      n_checks++; if (got_q[2] !== 32'd56) begin n_fail++; $display("FAIL pp_pushed_job: got %0d expected 56", got_q[2]); end
    end
  endtask

  task automatic test_random();
    bit ok, push_done;
    int n_ok;
    logic [WIDTH-1:0] a, b;
    core_rand = 1'b1; got_q.delete(); n_ok = 0; push_done = 1'b0;
    fork
      begin
        for (int j = 0; j < 12; j++) begin
          a = 16'($urandom); b = 16'($urandom);
          if (j == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
          if (j == 1) begin a = 16'h0000; b = 16'h1234; end
          push_job(a, b, ok);
          if (ok) n_ok++;
          repeat ($urandom_range(0, 3)) tick();
        end
        push_done = 1'b1;
      end
      begin
        while (!push_done) begin
          tick();
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_idle(2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_drain: idle %b expected 1", ok); end
    n_checks++; if (n_ok != 12 || got_q.size() != 12) begin n_fail++; $display("FAIL rand_count: accepted %0d results %0d expected 12/12", n_ok, got_q.size()); end
    core_rand = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    core_rand = 1'b0; core_lat = 30; out_ready = 1'b1; got_q.delete();
    push_job(16'd21, 16'd2, ok);
    push_job(16'd22, 16'd3, ok);
    push_job(16'd23, 16'd4, ok);
    repeat (3) tick();
    n_checks++; if (count !== CW'(3) || busy !== 1'b1) begin n_fail++; $display("FAIL rm_queued: count %0d busy %b expected 3/1", count, busy); end
    mon_en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (start !== 1'b0 || out_valid !== 1'b0 || out_product !== '0 || mult_a !== '0 || mult_b !== '0 ||
        err !== 1'b0 || count !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rm_async_clear: start %b ov %b prod %h a %h b %h err %b count %0d busy %b expected all 0",
                         start, out_valid, out_product, mult_a, mult_b, err, count, busy);
    end
    repeat (2) tick();
    job_q.delete(); res_q.delete(); got_q.delete();
    rst = 1'b1;
    mon_en = 1'b1;
    core_lat = 4;
    tick();
    n_checks++; if (count !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_after_release: count %0d busy %b expected 0/0", count, busy); end
    push_job(16'd9, 16'd10, ok);
    wait_idle(200, ok);
    n_checks++; if (!ok || got_q.size() != 1) begin n_fail++; $display("FAIL rm_new_job: idle %b results %0d expected 1/1", ok, got_q.size()); end
  endtask

`ifdef MULT_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, found, saw_ov;
    int err_k;
    mon_en = 1'b0; core_rand = 1'b0; core_lat = 3; core_mute = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'd1; in_b = 16'd2; tick();
    in_a = 16'd3; in_b = 16'd4; tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL to_start: seen %b expected 1", found); end
    err_k = -1; saw_ov = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_valid) saw_ov = 1'b1;
      if (err) begin err_k = i; break; end
    end
    n_checks++; if (err_k != 9) begin n_fail++; $display("FAIL to_err_cycle: got %0d expected 9", err_k); end
    n_checks++; if (saw_ov || count !== CW'(1) || busy !== 1'b0) begin n_fail++; $display("FAIL to_drop: out_valid %b count %0d busy %b expected 0/1/0", saw_ov, count, busy); end
    core_mute = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start) begin found = 1'b1; break; end
    end
    n_checks++; if (!found || mult_a !== 16'd3 || mult_b !== 16'd4) begin n_fail++; $display("FAIL to_next_issue: start %b a %0d b %0d expected 1/3/4", found, mult_a, mult_b); end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin found = 1'b1; break; end
    end
    n_checks++; if (!found || out_product !== 32'd12 || err !== 1'b1) begin n_fail++; $display("FAIL to_next_result: ov %b product %0d err %b expected 1/12/1", found, out_product, err); end
    wait_idle(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL to_idle: idle %b expected 1", ok); end
    rst = 1'b0;
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_reset: got %b expected 0", err); end
    rst = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_push_pop();
    test_random();
    test_reset_mid();
`ifdef MULT_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
